// File: rtl/ram_wr_control_pkg.sv
// Shared definitions for the frame-buffer write/read controllers.
package ram_wr_control_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/ram_wr_control.sv
// Write-side controller: streams one sop/eop-delimited frame of DEPTH words
// into the frame buffer, launches the reader with rd_sop, then holds the
// buffer until downstream releases it.
module ram_wr_control
  import ram_wr_control_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              rd_sop,
  input  logic              buf_release,
  output logic              frame_err,
  output logic              busy
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_sop_q, rd_sop_d;
  logic                err_q, err_d;
  logic                accept;
  logic                restart;
  logic [ADDR_W:0]     idx;

  assign accept    = in_valid & in_ready_q;
  assign in_ready  = in_ready_q;
  assign ram_wr_en = wr_en_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;
  assign rd_sop    = rd_sop_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

  // Next-state, write-path and pulse generation.
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    wr_en_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    rd_pend_d = 1'b0;
    rd_sop_d  = rd_pend_q;
    err_d     = 1'b0;
    restart   = 1'b0;
    idx       = wr_cnt_q;

    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if ((state_q == IDLE) && !in_sop) begin
            err_d = 1'b1;
          end else begin
            // An sop beat always lands at address 0, whether it opens a
            // frame or restarts one; the eop/last-word checks then apply
            // to that effective index.
            idx     = in_sop ? '0 : wr_cnt_q;
            restart = (state_q == FILL) && in_sop;
            wr_en_d = 1'b1;
            waddr_d = idx[ADDR_W-1:0];
            wdata_d = in_data;
            if (idx == LAST_IDX) begin
              state_d   = HOLD;
              wr_cnt_d  = idx + CNT_ONE;
              rd_pend_d = 1'b1;
              err_d     = restart | ~in_eop;
            end else if (in_eop) begin
              state_d  = IDLE;
              wr_cnt_d = '0;
              err_d    = 1'b1;
            end else begin
              state_d  = FILL;
              wr_cnt_d = idx + CNT_ONE;
              err_d    = restart;
            end
          end
        end
      end
      HOLD: begin
        if (buf_release) begin
          state_d  = IDLE;
          wr_cnt_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        wr_cnt_d = '0;
      end
    endcase

    in_ready_d = (state_d != HOLD);
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_sop_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rd_pend_q  <= rd_pend_d;
      rd_sop_q   <= rd_sop_d;
      err_q      <= err_d;
    end
  end

endmodule
